// File: rtl/dm_cache_pkg.sv
// rtl/dm_cache_pkg.sv - shared state encoding and address-split helpers for the direct-mapped cache
package dm_cache_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  // Helpers operate on a zero-extended address; callers size-cast the result.
  function automatic logic [31:0] index_of(input logic [31:0] addr, input int unsigned index_w);
    return addr & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int unsigned index_w);
    return addr >> index_w;
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// rtl/dm_cache_array.sv - line storage {valid, dirty, tag, data}: sync write, comb read, bulk valid clear
module dm_cache_array #(
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 4,
  parameter int INDEX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  input  logic               we,
  input  logic               wdirty,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [DATA_W-1:0]  wdata,
  output logic               rvalid,
  output logic               rdirty,
  output logic [TAG_W-1:0]   rtag,
  output logic [DATA_W-1:0]  rdata
);
  import dm_cache_pkg::*;

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Only the state bits are reset; tag and data are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= wdirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[idx]  <= wtag;
      data_q[idx] <= wdata;
    end
  end

  assign rvalid = valid_q[idx];
  assign rdirty = dirty_q[idx];
  assign rtag   = tag_q[idx];
  assign rdata  = data_q[idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-back cache with miss FSM; DM_CACHE_STATS_EN adds hit/miss counters
module dm_cache_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  import dm_cache_pkg::*;

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t              state_q, state_d;
  logic                ack_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [DATA_W-1:0]   line_data;
  logic                hit, accept;
  logic                arr_we, arr_dirty;
  logic [DATA_W-1:0]   arr_data;

  assign idx = INDEX_W'(index_of(32'(cpu_addr), INDEX_W));
  assign tag = TAG_W'(tag_of(32'(cpu_addr), INDEX_W));
  assign hit = line_valid && (line_tag == tag);
  // The ack cycle itself is the mandatory idle gap before the next accept.
  assign accept = (state_q == IDLE) && cpu_req && !cpu_ack;

  dm_cache_array #(
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .idx    (idx),
    .we     (arr_we),
    .wdirty (arr_dirty),
    .wtag   (tag),
    .wdata  (arr_data),
    .rvalid (line_valid),
    .rdirty (line_dirty),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cpu_ack   <= ack_d;
      cpu_rdata <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    rdata_d   = cpu_rdata;
    arr_we    = 1'b0;
    arr_dirty = 1'b0;
    arr_data  = cpu_wdata;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            ack_d = 1'b1;
            if (cpu_we) begin
              arr_we    = 1'b1;
              arr_dirty = 1'b1;
            end else begin
              rdata_d = line_data;
            end
          end else if (line_valid && line_dirty) begin
            state_d = WB;
          end else begin
            state_d = FILL;
          end
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, idx};
        mem_wdata = line_data;
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = cpu_addr;
        if (mem_ack) begin
          arr_we   = 1'b1;
          arr_data = mem_rdata;
          state_d  = RESP;
        end
      end
      RESP: begin
        // Line is now guaranteed to hit; replay the access against it.
        ack_d   = 1'b1;
        state_d = IDLE;
        if (cpu_we) begin
          arr_we    = 1'b1;
          arr_dirty = 1'b1;
        end else begin
          rdata_d = line_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DM_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (hit && hit_cnt != 16'hFFFF)    hit_cnt  <= hit_cnt + 16'd1;
      if (!hit && miss_cnt != 16'hFFFF)  miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard bench for dm_cache_ctrl with a fixed-latency RAM responder
module tb_dm_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic       cpu_ack, mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
`ifdef DM_CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dm_cache_ctrl #(.DATA_W(8), .ADDR_W(8), .INDEX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  typedef struct {logic we; logic [7:0] addr; logic [7:0] data;} mem_exp_t;
  typedef struct {logic we; logic [7:0] data;} cpu_exp_t;

  mem_exp_t mem_q[$];
  cpu_exp_t cpu_q[$];

  int checks = 0;
  int errors = 0;
  int ack_total = 0;
  int mcnt = 0;
  int lat;
  int base;
  logic prev_ack = 1'b0;
  logic mem_hold = 1'b0;
  logic [7:0] fill_data = '0;
  localparam int MEM_LAT = 2;

  // RAM model: ack in the (MEM_LAT+1)th cycle of a held request.
  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (rst || !mem_req || mem_hold) mcnt = 0;
    else if (mcnt == MEM_LAT) begin
      mem_ack   = 1'b1;
      mem_rdata = fill_data;
      mcnt      = 0;
    end else mcnt++;
  end

  always @(negedge clk) begin
    cpu_exp_t ce;
    mem_exp_t me;
    logic bad;
    if (!rst) begin
      if (cpu_ack && mem_req) begin
        checks++; errors++;
        $display("FAIL ack_with_mem_req actual cpu_ack=1 mem_req=1 required not both");
      end
      if (cpu_ack && prev_ack) begin
        checks++; errors++;
        $display("FAIL back_to_back_ack actual two consecutive acks required idle gap");
      end
      if (cpu_ack) begin
        ack_total++;
        checks++;
        if (cpu_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack actual ack required none");
        end else begin
          ce = cpu_q.pop_front();
          if (!ce.we && cpu_rdata !== ce.data) begin
            errors++;
            $display("FAIL cpu_rdata actual %02h required %02h", cpu_rdata, ce.data);
          end
        end
      end
      if (mem_req && mem_ack) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_mem actual we=%0b addr=%02h required none", mem_we, mem_addr);
        end else begin
          me  = mem_q.pop_front();
          bad = (mem_we !== me.we) || (mem_addr !== me.addr) || (me.we && mem_wdata !== me.data);
          if (bad) begin
            errors++;
            $display("FAIL mem_txn actual we=%0b addr=%02h wdata=%02h required we=%0b addr=%02h wdata=%02h",
                     mem_we, mem_addr, mem_wdata, me.we, me.addr, me.data);
          end
        end
      end
    end
    prev_ack = cpu_ack;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_mem(input logic we, input logic [7:0] addr, input logic [7:0] data);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.data = data;
    mem_q.push_back(e);
  endtask

  task automatic push_cpu(input logic we, input logic [7:0] data);
    cpu_exp_t e;
    e.we = we; e.data = data;
    cpu_q.push_back(e);
  endtask

  // Called just after a rising edge; returns cycles from issue to ack.
  task automatic cpu_op(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp, output int n);
    push_cpu(we, we ? wd : exp);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!cpu_ack && n < 50);
    if (!cpu_ack) begin
      checks++; errors++;
      $display("FAIL cpu_timeout actual no ack after %0d cycles required ack", n);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ack",   cpu_ack,   0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req",   mem_req,   0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    fill_data = 8'hA1; expect_mem(0, 8'h35, 0);
    cpu_op(0, 8'h35, 0, 8'hA1, lat);       chk("miss_latency", lat, 5);
    cpu_op(0, 8'h35, 0, 8'hA1, lat);       chk("hit_latency", lat, 1);
    cpu_op(1, 8'h35, 8'h5C, 0, lat);       chk("write_hit_latency", lat, 1);

    fill_data = 8'hB2; expect_mem(1, 8'h35, 8'h5C); expect_mem(0, 8'h45, 0);
    cpu_op(0, 8'h45, 0, 8'hB2, lat);

    fill_data = 8'h33; expect_mem(0, 8'h12, 0);
    cpu_op(1, 8'h12, 8'h77, 0, lat);
    cpu_op(0, 8'h12, 0, 8'h77, lat);       chk("write_alloc_hit", lat, 1);

    fill_data = 8'hC3; expect_mem(1, 8'h12, 8'h77); expect_mem(0, 8'h22, 0);
    cpu_op(0, 8'h22, 0, 8'hC3, lat);
    cpu_op(1, 8'h22, 8'h99, 0, lat);       chk("dirty_before_rst", lat, 1);

    // Abandon a fill with reset; the dirty line at index 2 must not be written back.
    mem_hold = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h35;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("fill_pending_req", mem_req, 1);
    chk("fill_pending_addr", mem_addr, 8'h35);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_hold = 1'b0;
    @(negedge clk);
    chk("rst_mid_miss_req", mem_req, 0);
`ifdef DM_CACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    @(posedge clk); #1;

    fill_data = 8'hEE; expect_mem(0, 8'h22, 0);
    cpu_op(0, 8'h22, 0, 8'hEE, lat);
    fill_data = 8'hD4; expect_mem(0, 8'h35, 0);
    cpu_op(0, 8'h35, 0, 8'hD4, lat);       chk("post_rst_miss_latency", lat, 5);

    // Request held high across three hits.
    base = ack_total;
    repeat (3) push_cpu(1, 8'h66);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h35; cpu_wdata = 8'h66;
    repeat (6) @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("held_req_acks", ack_total - base, 3);
    @(posedge clk); #1;
    cpu_op(0, 8'h35, 0, 8'h66, lat);       chk("held_write_hit", lat, 1);
`ifdef DM_CACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 4);
    chk("miss_cnt", miss_cnt, 2);
`endif

    repeat (3) @(posedge clk);
    chk("cpu_queue_empty", cpu_q.size(), 0);
    chk("mem_queue_empty", mem_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
